alu_wb_stage: RTL and testbench

Execute-to-writeback pipeline stage that sits directly downstream of the ALU. It registers the ALU result and destination register, and holds the architectural C/V/Z flags that feed back into the ALU `cin`/`vin`. It stretches an instruction over extra cycles when the ALU raises its multi-cycle flag, and uses a valid/ready handshake to stall execute when writeback is not accepting.

---
 rtl/alu_wb_stage_pkg.sv | 25 ++
 rtl/alu_wb_stage_flags.sv | 40 ++++
 rtl/alu_wb_stage.sv | 147 ++++++++++++++
 tb/tb_alu_wb_stage.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_wb_stage_pkg.sv
// alu_wb_stage_pkg
//   Shared definitions for the execute-to-writeback stage: opcode encodings
//   used by the stage (BTST is the only one it decodes) and the FSM state
//   encodings WB_IDLE / WB_MCP.
package alu_wb_stage_pkg;

    localparam int OPCODE_W = 6;

    // Opcode encodings shared with the decoder and the ALU.
    localparam logic [OPCODE_W-1:0] ADD  = 6'h00;
    localparam logic [OPCODE_W-1:0] SUB  = 6'h01;
    localparam logic [OPCODE_W-1:0] AND  = 6'h02;
    localparam logic [OPCODE_W-1:0] OR   = 6'h03;
    localparam logic [OPCODE_W-1:0] XOR  = 6'h04;
    localparam logic [OPCODE_W-1:0] BTST = 6'h0C;

    // Width of the multi-cycle wait counter (MCP_CYCLES is 1..7).
    localparam int MCP_CNT_W = 3;

    typedef enum logic [0:0] {
        WB_IDLE = 1'b0,
        WB_MCP  = 1'b1
    } wb_state_t;

endpackage : alu_wb_stage_pkg

// File: rtl/alu_wb_stage_flags.sv
// alu_flags
//   Architectural C/V/Z flag register. When load is high the flags take the
//   ALU carry/overflow and a zero-test of the ALU result.
// Ports:
//   clk, reset_b     : clock, asynchronous active-low reset
//   load             : update flags on this edge
//   alu_cout/alu_vout: next C / V
//   alu_dout         : result used for the Z compare
//   flag_c/v/z       : current flags
module alu_flags #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_b,
    input  logic              load,
    input  logic              alu_cout,
    input  logic              alu_vout,
    input  logic [DATA_W-1:0] alu_dout,
    output logic              flag_c,
    output logic              flag_v,
    output logic              flag_z
);

    logic dout_is_zero;

    assign dout_is_zero = (alu_dout == '0);

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            flag_c <= 1'b0;
            flag_v <= 1'b0;
            flag_z <= 1'b0;
        end else if (load) begin
            flag_c <= alu_cout;
            flag_v <= alu_vout;
            flag_z <= dout_is_zero;
        end
    end

endmodule : alu_flags

// File: rtl/alu_wb_stage.sv
// alu_wb_stage
//   Execute-to-writeback stage downstream of the ALU. Registers the ALU
//   result and destination, owns the C/V/Z flags, stretches multi-cycle ALU
//   operations, and back-pressures execute when writeback stalls.
// Handshake: a transfer happens on a rising edge where valid and ready are
//   both high. ex_valid/ex_ready move an instruction from execute into this
//   stage; wb_valid/wb_ready move a result from this stage into the register
//   file. Producers keep valid and payload stable until the transfer.
// Ports:
//   clk, reset_b                  : clock, asynchronous active-low reset
//   ex_valid/ex_ready             : execute handshake
//   ex_opcode/ex_rdest/ex_wen/ex_setflags : instruction attributes
//   alu_dout/alu_cout/alu_vout/alu_mcp    : ALU outputs
//   flush                         : kill instruction in execute / pending MCP
//   wb_valid/wb_ready             : writeback handshake
//   wb_data/wb_rdest/wb_wen       : writeback payload
//   flag_c/flag_v/flag_z          : architectural flags
//   dbg_state                     : current FSM state
module alu_wb_stage
    import alu_wb_stage_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int RADDR_W    = 4,
    parameter int MCP_CYCLES = 1
) (
    input  logic               clk,
    input  logic               reset_b,
    input  logic               ex_valid,
    output logic               ex_ready,
    input  logic [5:0]         ex_opcode,
    input  logic [RADDR_W-1:0] ex_rdest,
    input  logic               ex_wen,
    input  logic               ex_setflags,
    input  logic [DATA_W-1:0]  alu_dout,
    input  logic               alu_cout,
    input  logic               alu_vout,
    input  logic               alu_mcp,
    input  logic               flush,
    output logic               wb_valid,
    input  logic               wb_ready,
    output logic [DATA_W-1:0]  wb_data,
    output logic [RADDR_W-1:0] wb_rdest,
    output logic               wb_wen,
    output logic               flag_c,
    output logic               flag_v,
    output logic               flag_z,
    output wb_state_t          dbg_state
);

    localparam logic [MCP_CNT_W-1:0] MCP_LOAD = MCP_CNT_W'(MCP_CYCLES);

    wb_state_t              state_q, state_d;
    logic [MCP_CNT_W-1:0]   cnt_q, cnt_d;
    logic                   out_free;
    logic                   accept;
    logic                   capture;

    // Output register can take a new result if empty or draining this edge.
    // This is a combinational path from wb_ready to ex_ready (no skid buffer).
    assign out_free  = !wb_valid || wb_ready;
    assign ex_ready  = (state_q == WB_IDLE) && out_free && !flush;
    assign accept    = ex_valid && ex_ready;
    assign dbg_state = state_q;

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q <= WB_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        case (state_q)
            WB_IDLE: begin
                if (accept) begin
                    if (alu_mcp) begin
                        state_d = WB_MCP;
                        cnt_d   = MCP_LOAD;
                    end else begin
                        capture = 1'b1;
                    end
                end
            end
            WB_MCP: begin
                if (flush) begin
                    state_d = WB_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == MCP_CNT_W'(1)) begin
                    // Execute has held operands stable, so alu_dout now
                    // carries the final multi-cycle result.
                    if (out_free) begin
                        capture = 1'b1;
                        state_d = WB_IDLE;
                        cnt_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q - MCP_CNT_W'(1);
                end
            end
            default: begin
                state_d = WB_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output register. A capture overrides a drain on the same edge, so
    // wb_valid stays high across back-to-back results. wb_wen is cleared
    // together with wb_valid so it is always qualified by it.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            wb_valid <= 1'b0;
            wb_wen   <= 1'b0;
            wb_data  <= '0;
            wb_rdest <= '0;
        end else if (capture) begin
            wb_valid <= 1'b1;
            wb_wen   <= ex_wen && (ex_opcode != BTST);
            wb_data  <= alu_dout;
            wb_rdest <= ex_rdest;
        end else if (wb_ready) begin
            wb_valid <= 1'b0;
            wb_wen   <= 1'b0;
        end
    end

    alu_flags #(
        .DATA_W (DATA_W)
    ) u_alu_flags (
        .clk      (clk),
        .reset_b  (reset_b),
        .load     (capture && ex_setflags),
        .alu_cout (alu_cout),
        .alu_vout (alu_vout),
        .alu_dout (alu_dout),
        .flag_c   (flag_c),
        .flag_v   (flag_v),
        .flag_z   (flag_z)
    );

endmodule : alu_wb_stage

// File: tb/tb_alu_wb_stage.sv
module tb_alu_wb_stage;
  import alu_wb_stage_pkg::*;

  localparam int DATA_W  = 32;
  localparam int RADDR_W = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_b = 1'b0;
  always #5 clk = ~clk;

  logic               ex_valid, ex_ready, ex_wen, ex_setflags;
  logic [5:0]         ex_opcode;
  logic [RADDR_W-1:0] ex_rdest;
  logic [DATA_W-1:0]  alu_dout;
  logic               alu_cout, alu_vout, alu_mcp, flush;
  logic               wb_valid, wb_ready, wb_wen;
  logic [DATA_W-1:0]  wb_data;
  logic [RADDR_W-1:0] wb_rdest;
  logic               flag_c, flag_v, flag_z;
  wb_state_t          dbg_state;

  alu_wb_stage #(
    .DATA_W     (DATA_W),
    .RADDR_W    (RADDR_W),
    .MCP_CYCLES (2)
  ) dut (
    .clk         (clk),
    .reset_b     (reset_b),
    .ex_valid    (ex_valid),
    .ex_ready    (ex_ready),
    .ex_opcode   (ex_opcode),
    .ex_rdest    (ex_rdest),
    .ex_wen      (ex_wen),
    .ex_setflags (ex_setflags),
    .alu_dout    (alu_dout),
    .alu_cout    (alu_cout),
    .alu_vout    (alu_vout),
    .alu_mcp     (alu_mcp),
    .flush       (flush),
    .wb_valid    (wb_valid),
    .wb_ready    (wb_ready),
    .wb_data     (wb_data),
    .wb_rdest    (wb_rdest),
    .wb_wen      (wb_wen),
    .flag_c      (flag_c),
    .flag_v      (flag_v),
    .flag_z      (flag_z),
    .dbg_state   (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [DATA_W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Sample a committed result against the head of the expected queue.
  task automatic check_commit(input string tag);
    logic [DATA_W-1:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_queue_empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check(tag, wb_data, e);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [5:0] op, input logic [RADDR_W-1:0] rd,
                       input logic wen, input logic sf, input logic [DATA_W-1:0] d,
                       input logic c, input logic ov, input logic mcp);
    ex_valid    = v;
    ex_opcode   = op;
    ex_rdest    = rd;
    ex_wen      = wen;
    ex_setflags = sf;
    alu_dout    = d;
    alu_cout    = c;
    alu_vout    = ov;
    alu_mcp     = mcp;
  endtask

  task automatic idle_ex();
    drive(1'b0, ADD, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    idle_ex();
    flush    = 1'b0;
    wb_ready = 1'b1;

    // Reset state
    #12;
    check("rst_ex_ready", 32'(ex_ready), 32'd1);
    check("rst_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_wb_data", wb_data, 32'd0);
    check("rst_wb_wen", 32'(wb_wen), 32'd0);
    check("rst_flags", {29'd0, flag_c, flag_v, flag_z}, 32'd0);
    check("rst_state", 32'(dbg_state), 32'(WB_IDLE));
    #10 reset_b = 1'b1;

    // ADD: 1-cycle capture, C=1 Z=0
    drive(1'b1, ADD, 4'd3, 1'b1, 1'b1, 32'h5, 1'b1, 1'b0, 1'b0);
    exp_q.push_back(32'h5);
    #1 check("add_ex_ready", 32'(ex_ready), 32'd1);
    tick();
    idle_ex();
    check("add_wb_valid", 32'(wb_valid), 32'd1);
    check_commit("add_wb_data");
    check("add_wb_rdest", 32'(wb_rdest), 32'd3);
    check("add_wb_wen", 32'(wb_wen), 32'd1);
    check("add_flags_cvz", {29'd0, flag_c, flag_v, flag_z}, 32'b100);
    check("add_ex_ready_after", 32'(ex_ready), 32'd1);

    // BTST: never writes, Z=1, V=1
    drive(1'b1, BTST, 4'd6, 1'b1, 1'b1, 32'h0, 1'b0, 1'b1, 1'b0);
    exp_q.push_back(32'h0);
    tick();
    idle_ex();
    check("btst_wb_valid", 32'(wb_valid), 32'd1);
    check_commit("btst_wb_data");
    check("btst_wb_wen", 32'(wb_wen), 32'd0);
    check("btst_flags_cvz", {29'd0, flag_c, flag_v, flag_z}, 32'b011);
    tick();
    check("btst_drain", 32'(wb_valid), 32'd0);

    // Multi-cycle (MCP_CYCLES=2): result sampled at the end of the wait
    drive(1'b1, ADD, 4'd7, 1'b1, 1'b0, 32'h11, 1'b0, 1'b0, 1'b1);
    exp_q.push_back(32'h22);
    tick();
    check("mcp_state", 32'(dbg_state), 32'(WB_MCP));
    check("mcp_ex_ready_w1", 32'(ex_ready), 32'd0);
    alu_dout = 32'h22;
    tick();
    check("mcp_ex_ready_w2", 32'(ex_ready), 32'd0);
    check("mcp_no_early_valid", 32'(wb_valid), 32'd0);
    tick();
    idle_ex();
    check("mcp_wb_valid", 32'(wb_valid), 32'd1);
    check_commit("mcp_wb_data");
    check("mcp_wb_rdest", 32'(wb_rdest), 32'd7);
    check("mcp_ex_ready_back", 32'(ex_ready), 32'd1);
    check("mcp_flags_kept", {29'd0, flag_c, flag_v, flag_z}, 32'b011);
    tick();
    check("mcp_drain", 32'(wb_valid), 32'd0);

    // Back-pressure: result held 3 cycles, pending op captured on release
    drive(1'b1, ADD, 4'd2, 1'b1, 1'b0, 32'hA5, 1'b0, 1'b0, 1'b0);
    exp_q.push_back(32'hA5);
    tick();
    wb_ready = 1'b0;
    drive(1'b1, ADD, 4'd4, 1'b1, 1'b0, 32'hB6, 1'b0, 1'b0, 1'b0);
    #1 check("bp_ex_ready_comb", 32'(ex_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_hold_data", wb_data, 32'hA5);
      check("bp_hold_valid", 32'(wb_valid), 32'd1);
      check("bp_ex_ready", 32'(ex_ready), 32'd0);
    end
    check_commit("bp_first_data");
    wb_ready = 1'b1;
    exp_q.push_back(32'hB6);
    #1 check("bp_release_ready", 32'(ex_ready), 32'd1);
    tick();
    idle_ex();
    check("bp_next_valid", 32'(wb_valid), 32'd1);
    check_commit("bp_next_data");
    check("bp_next_rdest", 32'(wb_rdest), 32'd4);
    tick();
    check("bp_drain", 32'(wb_valid), 32'd0);

    // Flush during MCP wait: no result, flags untouched
    drive(1'b1, ADD, 4'd5, 1'b1, 1'b0, 32'h33, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, ADD, 4'd6, 1'b1, 1'b1, 32'h44, 1'b1, 1'b0, 1'b1);
    #1 check("fl_accept_ready", 32'(ex_ready), 32'd1);
    tick();
    check("fl_in_mcp", 32'(dbg_state), 32'(WB_MCP));
    check("fl_old_drained", 32'(wb_valid), 32'd0);
    flush = 1'b1;
    tick();
    check("fl_state_idle", 32'(dbg_state), 32'(WB_IDLE));
    check("fl_no_valid", 32'(wb_valid), 32'd0);
    check("fl_flags_kept", {29'd0, flag_c, flag_v, flag_z}, 32'b011);
    flush = 1'b0;
    idle_ex();
    #1 check("fl_ready_after", 32'(ex_ready), 32'd1);
    tick();
    tick();
    check("fl_no_late_valid", 32'(wb_valid), 32'd0);

    // Flush with an older held result: result still commits
    drive(1'b1, ADD, 4'd8, 1'b1, 1'b0, 32'h55, 1'b0, 1'b0, 1'b0);
    exp_q.push_back(32'h55);
    tick();
    wb_ready = 1'b0;
    flush    = 1'b1;
    alu_dout = 32'h66;
    #1 check("flh_ex_ready", 32'(ex_ready), 32'd0);
    tick();
    check("flh_valid_held", 32'(wb_valid), 32'd1);
    check_commit("flh_data_held");
    wb_ready = 1'b1;
    tick();
    check("flh_committed", 32'(wb_valid), 32'd0);
    check("flh_no_new_data", wb_data, 32'h55);
    flush = 1'b0;

    // Asynchronous reset in the middle of an MCP wait
    drive(1'b1, ADD, 4'd9, 1'b1, 1'b1, 32'h77, 1'b1, 1'b1, 1'b1);
    tick();
    check("ar_in_mcp", 32'(dbg_state), 32'(WB_MCP));
    #2 reset_b = 1'b0;
    #1;
    check("ar_state", 32'(dbg_state), 32'(WB_IDLE));
    check("ar_ex_ready", 32'(ex_ready), 32'd1);
    check("ar_wb_valid", 32'(wb_valid), 32'd0);
    check("ar_wb_data", wb_data, 32'd0);
    check("ar_flags", {29'd0, flag_c, flag_v, flag_z}, 32'd0);
    idle_ex();
    #2 reset_b = 1'b1;
    tick();
    check("ar_post_ready", 32'(ex_ready), 32'd1);
    check("ar_post_valid", 32'(wb_valid), 32'd0);
    check("ar_post_state", 32'(dbg_state), 32'(WB_IDLE));

    // ---------------- report ----------------
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_alu_wb_stage
